// File: rtl/memShare_config_pkg.sv
// Shared configuration for the memShare access scheduler.
// Holds the default sizing and the address/source/port types used by the
// scheduler and by code that talks to it at the default configuration.
// Optional feature macro used by this slice: MEMSHARE_STARVE_CNT_EN.
package memShare_config_pkg;

  localparam int DEFAULT_RQST_NUM       = 4;
  localparam int DEFAULT_SHARE_PORT_NUM = 2;
  localparam int DEFAULT_ADDR_W         = 8;
  localparam int DEFAULT_SRC_W          = $clog2(DEFAULT_RQST_NUM);
  localparam int DEFAULT_WAIT_CNT_W     = 4;

  typedef logic [DEFAULT_ADDR_W-1:0] memshare_addr_t;
  typedef logic [DEFAULT_SRC_W-1:0]  memshare_src_t;

  typedef struct packed {
    logic           valid;
    memshare_addr_t addr;
    memshare_src_t  src;
  } memshare_port_t;

endpackage

// File: rtl/memshare_rr_picker.sv
// Combinational multi-grant round-robin scan for the memShare scheduler.
// Scans requesters starting at rr_ptr (wrapping modulo RQST_NUM) and hands
// the first SHARE_PORT_NUM pending ones to ports 0, 1, ... in scan order.
// Requesters flagged in prio_mask are taken in a first pass, so they win
// over every unflagged requester; within each pass order is the rr order.
// Ports:
//   pend_valid  : pending requests eligible this cycle (zero while stalled)
//   prio_mask   : requesters to serve first (all zero for pure round-robin)
//   rr_ptr      : scan start index
//   sel_idx     : per-port chosen requester index
//   sel_valid   : per-port selection valid
//   gnt         : per-requester grant mask
//   rr_ptr_next : one past the last selected index, or rr_ptr if none
module memshare_rr_picker #(
  parameter int RQST_NUM       = 4,
  parameter int SHARE_PORT_NUM = 2,
  parameter int SRC_W          = $clog2(RQST_NUM)
) (
  input  logic [RQST_NUM-1:0]       pend_valid,
  input  logic [RQST_NUM-1:0]       prio_mask,
  input  logic [SRC_W-1:0]          rr_ptr,
  output logic [SRC_W-1:0]          sel_idx [SHARE_PORT_NUM],
  output logic [SHARE_PORT_NUM-1:0] sel_valid,
  output logic [RQST_NUM-1:0]       gnt,
  output logic [SRC_W-1:0]          rr_ptr_next
);

  always_comb begin
    int   cnt;
    int   idx;
    logic cand;
    cnt         = 0;
    idx         = 0;
    cand        = 1'b0;
    sel_valid   = '0;
    gnt         = '0;
    rr_ptr_next = rr_ptr;
    for (int k = 0; k < SHARE_PORT_NUM; k++) begin
      sel_idx[k] = '0;
    end
    // pass 0 serves prioritised requesters, pass 1 the rest
    for (int pass = 0; pass < 2; pass++) begin
      for (int o = 0; o < RQST_NUM; o++) begin
        idx  = (int'(rr_ptr) + o) % RQST_NUM;
        cand = pend_valid[idx] & ((pass == 0) ? prio_mask[idx] : ~prio_mask[idx]);
        if (cand && (cnt < SHARE_PORT_NUM)) begin
          sel_idx[cnt]   = SRC_W'(idx);
          sel_valid[cnt] = 1'b1;
          gnt[idx]       = 1'b1;
          rr_ptr_next    = SRC_W'((idx + 1) % RQST_NUM);
          cnt            = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/memshare_access_sched.sv
// Multi-port access scheduler for the memShare datapath of the layered
// IB-LDPC decoder. Each requester owns a single-entry holding register; all
// pending entries are scheduled onto SHARE_PORT_NUM shared ports per cycle
// with a multi-grant round-robin policy. All state lives here; the scan
// itself is in memshare_rr_picker.
// Optional feature: define MEMSHARE_STARVE_CNT_EN to add per-requester
// saturating wait counters, the starve_flag output and starving-first
// priority.
// Ports:
//   sys_clk, rst    : clock, asynchronous active-high reset
//   rqst_valid/addr : per-requester request (addr i at [i*ADDR_W +: ADDR_W])
//   rqst_ready      : per-requester holding register empty (registered)
//   mem_stall       : shared memory refuses new accesses this cycle
//   port_valid/addr/src : registered per-port access and owning requester
//   rr_ptr_o        : round-robin start pointer (debug)
//   starve_flag     : per-requester starvation flag (feature build only)
module memshare_access_sched
  import memShare_config_pkg::*;
#(
  parameter int RQST_NUM       = DEFAULT_RQST_NUM,
  parameter int SHARE_PORT_NUM = DEFAULT_SHARE_PORT_NUM,
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int SRC_W          = $clog2(RQST_NUM)
`ifdef MEMSHARE_STARVE_CNT_EN
  , parameter int WAIT_CNT_W   = DEFAULT_WAIT_CNT_W
`endif
) (
  input  logic                             sys_clk,
  input  logic                             rst,
  input  logic [RQST_NUM-1:0]              rqst_valid,
  input  logic [RQST_NUM*ADDR_W-1:0]       rqst_addr,
  output logic [RQST_NUM-1:0]              rqst_ready,
  input  logic                             mem_stall,
  output logic [SHARE_PORT_NUM-1:0]        port_valid,
  output logic [SHARE_PORT_NUM*ADDR_W-1:0] port_addr,
  output logic [SHARE_PORT_NUM*SRC_W-1:0]  port_src,
  output logic [SRC_W-1:0]                 rr_ptr_o
`ifdef MEMSHARE_STARVE_CNT_EN
  , output logic [RQST_NUM-1:0]            starve_flag
`endif
);

  logic [RQST_NUM-1:0]       pend_valid_reg;
  logic [ADDR_W-1:0]         pend_addr_reg [RQST_NUM];
  logic [ADDR_W-1:0]         rqst_addr_arr [RQST_NUM];
  logic [SHARE_PORT_NUM-1:0] port_valid_reg;
  logic [ADDR_W-1:0]         port_addr_reg [SHARE_PORT_NUM];
  logic [SRC_W-1:0]          port_src_reg  [SHARE_PORT_NUM];
  logic [SRC_W-1:0]          rr_ptr_reg;

  logic [RQST_NUM-1:0]       accept;
  logic [RQST_NUM-1:0]       pick_pend;
  logic [RQST_NUM-1:0]       prio_mask;
  logic [SRC_W-1:0]          sel_idx [SHARE_PORT_NUM];
  logic [SHARE_PORT_NUM-1:0] sel_valid;
  logic [RQST_NUM-1:0]       gnt;
  logic [SRC_W-1:0]          rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < RQST_NUM; gi++) begin : g_rqst
      assign rqst_addr_arr[gi] = rqst_addr[gi*ADDR_W +: ADDR_W];
    end
    for (gi = 0; gi < SHARE_PORT_NUM; gi++) begin : g_port
      assign port_addr[gi*ADDR_W +: ADDR_W] = port_addr_reg[gi];
      assign port_src[gi*SRC_W +: SRC_W]    = port_src_reg[gi];
    end
  endgenerate

  // Ready comes straight from the holding register, so acceptance never
  // overlaps a grant of the same entry.
  assign rqst_ready = ~pend_valid_reg;
  assign accept     = rqst_valid & ~pend_valid_reg;
  // Hiding all entries from the picker during a stall gives no grants, an
  // unchanged rr_ptr and all-zero port_valid on the next edge.
  assign pick_pend  = mem_stall ? '0 : pend_valid_reg;
  assign rr_ptr_o   = rr_ptr_reg;
  assign port_valid = port_valid_reg;

`ifdef MEMSHARE_STARVE_CNT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt_reg [RQST_NUM];

  generate
    for (gi = 0; gi < RQST_NUM; gi++) begin : g_wait
      assign prio_mask[gi] = &wait_cnt_reg[gi];

      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          wait_cnt_reg[gi] <= '0;
        end else if (gnt[gi]) begin
          wait_cnt_reg[gi] <= '0;
        end else if (pend_valid_reg[gi] && !(&wait_cnt_reg[gi])) begin
          wait_cnt_reg[gi] <= wait_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign starve_flag = prio_mask;
`else
  assign prio_mask = '0;
`endif

  memshare_rr_picker #(
    .RQST_NUM       (RQST_NUM),
    .SHARE_PORT_NUM (SHARE_PORT_NUM),
    .SRC_W          (SRC_W)
  ) u_picker (
    .pend_valid  (pick_pend),
    .prio_mask   (prio_mask),
    .rr_ptr      (rr_ptr_reg),
    .sel_idx     (sel_idx),
    .sel_valid   (sel_valid),
    .gnt         (gnt),
    .rr_ptr_next (rr_ptr_next)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pend_valid_reg <= '0;
      port_valid_reg <= '0;
      rr_ptr_reg     <= '0;
      for (int i = 0; i < RQST_NUM; i++) begin
        pend_addr_reg[i] <= '0;
      end
      for (int k = 0; k < SHARE_PORT_NUM; k++) begin
        port_addr_reg[k] <= '0;
        port_src_reg[k]  <= '0;
      end
    end else begin
      pend_valid_reg <= (pend_valid_reg & ~gnt) | accept;
      rr_ptr_reg     <= rr_ptr_next;
      port_valid_reg <= sel_valid;
      for (int i = 0; i < RQST_NUM; i++) begin
        if (accept[i]) begin
          pend_addr_reg[i] <= rqst_addr_arr[i];
        end
      end
      // Unused ports keep their last address/source; only valid matters.
      for (int k = 0; k < SHARE_PORT_NUM; k++) begin
        if (sel_valid[k]) begin
          port_addr_reg[k] <= pend_addr_reg[sel_idx[k]];
          port_src_reg[k]  <= sel_idx[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_memshare_access_sched.sv
// Self-checking bench for memshare_access_sched at RQST_NUM=4,
// SHARE_PORT_NUM=2, ADDR_W=8: directed scenarios followed by random traffic,
// all checked against a queue-based scheduling model.
module tb_memshare_access_sched;
  import memShare_config_pkg::*;

  localparam int R  = 4;
  localparam int P  = 2;
  localparam int AW = 8;
  localparam int SW = 2;
`ifdef MEMSHARE_STARVE_CNT_EN
  localparam int WW    = 2;
  localparam int W_MAX = (1 << WW) - 1;
`endif

  logic            sys_clk;
  logic            rst;
  logic [R-1:0]    rqst_valid;
  logic [R*AW-1:0] rqst_addr;
  logic [R-1:0]    rqst_ready;
  logic            mem_stall;
  logic [P-1:0]    port_valid;
  logic [P*AW-1:0] port_addr;
  logic [P*SW-1:0] port_src;
  logic [SW-1:0]   rr_ptr_o;
`ifdef MEMSHARE_STARVE_CNT_EN
  logic [R-1:0]    starve_flag;
`endif

  memshare_access_sched #(
    .RQST_NUM       (R),
    .SHARE_PORT_NUM (P),
    .ADDR_W         (AW),
    .SRC_W          (SW)
`ifdef MEMSHARE_STARVE_CNT_EN
    , .WAIT_CNT_W   (WW)
`endif
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .rqst_valid (rqst_valid),
    .rqst_addr  (rqst_addr),
    .rqst_ready (rqst_ready),
    .mem_stall  (mem_stall),
    .port_valid (port_valid),
    .port_addr  (port_addr),
    .port_src   (port_src),
    .rr_ptr_o   (rr_ptr_o)
`ifdef MEMSHARE_STARVE_CNT_EN
    , .starve_flag (starve_flag)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit             m_pend [R];
  memshare_addr_t m_addr [R];
  int             m_rr;
  memshare_port_t m_port [P];
  int             m_wait [R];

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < R; i++) begin
      m_pend[i] = 0;
      m_addr[i] = '0;
      m_wait[i] = 0;
    end
    for (int k = 0; k < P; k++) m_port[k] = '0;
  endtask

  // One clock edge: grant from the pre-edge pending set, then accept.
  task automatic model_edge();
    bit acc [R];
    bit was_pend [R];
    bit granted [R];
    bit starving [R];
    int first [$];
    int rest [$];
    int order [$];
    int n;
    for (int i = 0; i < R; i++) begin
      acc[i]      = rqst_valid[i] && !m_pend[i];
      was_pend[i] = m_pend[i];
      granted[i]  = 0;
`ifdef MEMSHARE_STARVE_CNT_EN
      starving[i] = (m_wait[i] == W_MAX);
`else
      starving[i] = 0;
`endif
    end
    if (mem_stall) begin
      for (int k = 0; k < P; k++) m_port[k].valid = 1'b0;
    end else begin
      for (int o = 0; o < R; o++) begin
        int idx;
        idx = (m_rr + o) % R;
        if (m_pend[idx]) begin
          if (starving[idx]) first.push_back(idx);
          else               rest.push_back(idx);
        end
      end
      order = {first, rest};
      n = (order.size() < P) ? order.size() : P;
      for (int k = 0; k < P; k++) begin
        if (k < n) begin
          m_port[k].valid = 1'b1;
          m_port[k].addr  = m_addr[order[k]];
          m_port[k].src   = memshare_src_t'(order[k]);
          m_pend[order[k]]  = 0;
          granted[order[k]] = 1;
        end else begin
          m_port[k].valid = 1'b0;
        end
      end
      if (n > 0) m_rr = (order[n-1] + 1) % R;
    end
`ifdef MEMSHARE_STARVE_CNT_EN
    for (int i = 0; i < R; i++) begin
      if (granted[i])                          m_wait[i] = 0;
      else if (was_pend[i] && m_wait[i] < W_MAX) m_wait[i]++;
    end
`endif
    for (int i = 0; i < R; i++) begin
      if (acc[i]) begin
        m_pend[i] = 1;
        m_addr[i] = rqst_addr[i*AW +: AW];
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [R-1:0] exp_ready;
    logic [P-1:0] exp_pv;
    for (int i = 0; i < R; i++) exp_ready[i] = ~m_pend[i];
    for (int k = 0; k < P; k++) exp_pv[k] = m_port[k].valid;
    chk({tag, "_ready"}, 32'(rqst_ready), 32'(exp_ready));
    chk({tag, "_pvalid"}, 32'(port_valid), 32'(exp_pv));
    chk({tag, "_rr"}, 32'(rr_ptr_o), 32'(m_rr));
    for (int k = 0; k < P; k++) begin
      if (m_port[k].valid) begin
        chk($sformatf("%s_addr%0d", tag, k), 32'(port_addr[k*AW +: AW]), 32'(m_port[k].addr));
        chk($sformatf("%s_src%0d", tag, k), 32'(port_src[k*SW +: SW]), 32'(m_port[k].src));
      end
    end
`ifdef MEMSHARE_STARVE_CNT_EN
    begin
      logic [R-1:0] exp_sf;
      for (int i = 0; i < R; i++) exp_sf[i] = (m_wait[i] == W_MAX);
      chk({tag, "_starve"}, 32'(starve_flag), 32'(exp_sf));
    end
`endif
    $display("step %-12s ready=%b pvalid=%b paddr=%h psrc=%h rr=%0d", tag,
             rqst_ready, port_valid, port_addr, port_src, rr_ptr_o);
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [R-1:0] v, input logic [R*AW-1:0] a);
    rqst_valid = v;
    rqst_addr  = a;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    rqst_valid = '0;
    rqst_addr  = '0;
    mem_stall  = 1'b0;
    model_reset();
    step("rst0");
    step("rst1");
    rst = 1'b0;

    // 1: idle after reset
    step("idle");
    chk("idle_ready_c", 32'(rqst_ready), 32'h0000000f);
    chk("idle_pvalid_c", 32'(port_valid), 32'h0);
    chk("idle_rr_c", 32'(rr_ptr_o), 32'h0);

    // 2: all four request together
    drive(4'b1111, 32'h40302010);
    step("s2_acc");
    drive(4'b0000, '0);
    step("s2_e1");
    chk("s2_e1_pv_c", 32'(port_valid), 32'h3);
    chk("s2_e1_addr_c", 32'(port_addr), 32'h2010);
    chk("s2_e1_src_c", 32'(port_src), 32'h4);
    chk("s2_e1_rr_c", 32'(rr_ptr_o), 32'h2);
    step("s2_e2");
    chk("s2_e2_addr_c", 32'(port_addr), 32'h4030);
    chk("s2_e2_src_c", 32'(port_src), 32'he);
    chk("s2_e2_rr_c", 32'(rr_ptr_o), 32'h0);
    step("s2_drain");

    // 3: move rr_ptr to 1, then a lone request from requester 3 wraps it
    drive(4'b0001, 32'h000000aa);
    step("s3_acc0");
    drive(4'b0000, '0);
    step("s3_gnt0");
    chk("s3_rr1_c", 32'(rr_ptr_o), 32'h1);
    drive(4'b1000, 32'hbb000000);
    step("s3_acc3");
    drive(4'b0000, '0);
    step("s3_gnt3");
    chk("s3_pv_c", 32'(port_valid), 32'h1);
    chk("s3_src0_c", 32'(port_src[SW-1:0]), 32'h3);
    chk("s3_rr_c", 32'(rr_ptr_o), 32'h0);

    // 4: three stalled cycles with four pending
    drive(4'b1111, 32'h44332211);
    step("s4_acc");
    drive(4'b0000, '0);
    mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step($sformatf("s4_stall%0d", c));
      chk($sformatf("s4_stall%0d_pv_c", c), 32'(port_valid), 32'h0);
    end
    mem_stall = 1'b0;
    step("s4_rel1");
    chk("s4_rel1_src_c", 32'(port_src), 32'h4);
    chk("s4_rel1_addr_c", 32'(port_addr), 32'h2211);
    step("s4_rel2");
    chk("s4_rel2_src_c", 32'(port_src), 32'he);

    // 5: asynchronous reset with two pending and ports valid
    drive(4'b1111, 32'hd4c3b2a1);
    step("s5_acc");
    drive(4'b0000, '0);
    step("s5_busy");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("s5_arst");
    chk("s5_ready_c", 32'(rqst_ready), 32'h0000000f);
    chk("s5_pv_c", 32'(port_valid), 32'h0);
    chk("s5_addr_c", 32'(port_addr), 32'h0);
    chk("s5_src_c", 32'(port_src), 32'h0);
    step("s5_hold");
    rst = 1'b0;
    step("s5_idle");

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rqst_valid = R'($urandom);
      rqst_addr  = (R*AW)'($urandom);
      mem_stall  = ($urandom_range(0, 3) == 0);
      step($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
